// File: rtl/mem_stage.sv
// Memory-access stage: issues SRAM loads/stores over req/addr_ok/data_ok, extends load data,
// stalls until completion. Optional misaligned-address exception: MEM_UNALIGNED_EXC_EN.
module mem_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_sdata_i,
    input  logic              flush_i,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [REG_AW-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              stallreq_o
`ifdef MEM_UNALIGNED_EXC_EN
    ,
    output logic              excp_ale_o,
    output logic [ADDR_W-1:0] badvaddr_o
`endif
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              is_load, is_store, is_mem, sign_ext;
    logic [1:0]        size;
    logic              ale;
    logic [ADDR_W-1:0] addr_aligned;
    logic [3:0]        strb;
    logic [DATA_W-1:0] sdata_rep;
    logic [DATA_W-1:0] byte_lane, half_lane, ld_ext;

    logic              req, stall, we, excp;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SzWord;
        unique case (mem_op_i)
            4'd1:  begin is_load  = 1'b1; sign_ext = 1'b1; size = SzByte; end
            4'd2:  begin is_load  = 1'b1; size = SzByte; end
            4'd3:  begin is_load  = 1'b1; sign_ext = 1'b1; size = SzHalf; end
            4'd4:  begin is_load  = 1'b1; size = SzHalf; end
            4'd5:  begin is_load  = 1'b1; size = SzWord; end
            4'd9:  begin is_store = 1'b1; size = SzByte; end
            4'd10: begin is_store = 1'b1; size = SzHalf; end
            4'd11: begin is_store = 1'b1; size = SzWord; end
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

`ifdef MEM_UNALIGNED_EXC_EN
    assign ale = is_mem && (((size == SzHalf) && mem_addr_i[0]) ||
                            ((size == SzWord) && (mem_addr_i[1:0] != 2'b00)));
`else
    assign ale = 1'b0;
`endif

    always_comb begin
        addr_aligned = mem_addr_i;
        if (size == SzHalf) addr_aligned[0] = 1'b0;
        if (size == SzWord) addr_aligned[1:0] = 2'b00;
    end

    always_comb begin
        strb      = 4'b1111;
        sdata_rep = mem_sdata_i;
        if (size == SzByte) begin
            strb      = 4'b0001 << mem_addr_i[1:0];
            sdata_rep = {(DATA_W/8){mem_sdata_i[7:0]}};
        end else if (size == SzHalf) begin
            strb      = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            sdata_rep = {(DATA_W/16){mem_sdata_i[15:0]}};
        end
    end

    // Lane select then sign/zero extension of the returning read data.
    always_comb begin
        byte_lane = data_rdata >> {mem_addr_i[1:0], 3'b000};
        half_lane = data_rdata >> {mem_addr_i[1], 4'b0000};
        ld_ext    = data_rdata;
        if (size == SzByte) begin
            ld_ext = {{(DATA_W-8){sign_ext & byte_lane[7]}}, byte_lane[7:0]};
        end else if (size == SzHalf) begin
            ld_ext = {{(DATA_W-16){sign_ext & half_lane[15]}}, half_lane[15:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        stall   = 1'b0;
        we      = 1'b0;
        excp    = 1'b0;
        wdata   = wdata_i;
        unique case (state_q)
            StIdle: begin
                if (!is_mem) begin
                    we = we_i;
                end else if (ale) begin
                    excp = 1'b1;
                end else if (!flush_i) begin
                    req     = 1'b1;
                    stall   = 1'b1;
                    state_d = data_addr_ok ? StWait : StReq;
                end
            end
            StReq: begin
                stall = 1'b1;
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    req = 1'b1;
                    if (data_addr_ok) state_d = StWait;
                end
            end
            StWait: begin
                stall = 1'b1;
                if (data_data_ok) begin
                    // A flush coinciding with the data return has nothing left to drain.
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        rdata_d = ld_ext;
                        state_d = StDone;
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (is_load) begin
                    we    = we_i & ~flush_i;
                    wdata = rdata_q;
                end
            end
            StDrain: begin
                we = is_mem ? 1'b0 : we_i;
                if (data_data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Every output is forced low while reset is held, independent of the clock.
    always_comb begin
        data_req   = req & ~rst;
        data_wr    = req & ~rst & is_store;
        data_wstrb = (req && !rst && is_store) ? strb : 4'b0000;
        data_addr  = (req && !rst) ? addr_aligned : '0;
        data_wdata = (req && !rst && is_store) ? sdata_rep : '0;
        waddr_o    = rst ? '0 : waddr_i;
        wdata_o    = rst ? '0 : wdata;
        we_o       = we & ~rst;
        stallreq_o = stall & ~rst;
    end

`ifdef MEM_UNALIGNED_EXC_EN
    assign excp_ale_o = excp & ~rst;
    assign badvaddr_o = (excp && !rst) ? mem_addr_i : '0;
`else
    logic unused_excp;
    assign unused_excp = excp;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback results, a monitor pops
// and compares them on every non-stalled cycle; handshake details are checked directly.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        flush_i;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        we_o, stallreq_o;
`ifdef MEM_UNALIGNED_EXC_EN
    logic        excp_ale_o;
    logic [31:0] badvaddr_o;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .we_i         (we_i),
        .mem_op_i     (mem_op_i),
        .mem_addr_i   (mem_addr_i),
        .mem_sdata_i  (mem_sdata_i),
        .flush_i      (flush_i),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .we_o         (we_o),
        .stallreq_o   (stallreq_o)
`ifdef MEM_UNALIGNED_EXC_EN
        ,
        .excp_ale_o   (excp_ale_o),
        .badvaddr_o   (badvaddr_o)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ret_t;

    ret_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every non-stalled cycle is one retired instruction.
    always @(negedge clk) begin
        if (!rst && mon_en && !stallreq_o) begin
            if (sb_q.size() == 0) begin
                chk("retire_unexpected", {31'd0, we_o}, 32'd0);
            end else begin
                ret_t e;
                e = sb_q.pop_front();
                chk("retire_we", {31'd0, we_o}, {31'd0, e.we});
                chk("retire_waddr", {27'd0, waddr_o}, {27'd0, e.waddr});
                chk("retire_wdata", wdata_o, e.wdata);
            end
        end
    end

    task automatic set_in(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] wd, input logic [4:0] wa, input logic we);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        wdata_i     = wd;
        waddr_i     = wa;
        we_i        = we;
    endtask

    task automatic run_alu(input string name, input logic [3:0] op, input logic [31:0] wd,
                           input logic [4:0] wa, input logic we);
        set_in(op, 32'h0, 32'h0, wd, wa, we);
        sb_q.push_back('{we: we, waddr: wa, wdata: wd});
        @(negedge clk);
        chk({name, "_stall"}, {31'd0, stallreq_o}, 32'd0);
        chk({name, "_req"}, {31'd0, data_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Drives one memory access: addr_ok after ad cycles, data_ok dd cycles after that.
    task automatic run_access(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] wd,
                              input logic [4:0] wa, input int ad, input int dd,
                              input logic [31:0] rdata, input logic [31:0] exp_daddr,
                              input logic [3:0] exp_strb, input logic [31:0] exp_swd,
                              input logic exp_wr, input logic exp_we,
                              input logic [31:0] exp_wdata, input int exp_stalls,
                              input int exp_reqs);
        int  k = 0, stalls = 0, reqs = 0;
        bit  done = 0;
        set_in(op, addr, sdata, wd, wa, 1'b1);
        data_rdata = rdata;
        sb_q.push_back('{we: exp_we, waddr: wa, wdata: exp_wdata});
        while (!done && k < 40) begin
            data_addr_ok = (k == ad);
            data_data_ok = (k == ad + dd);
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (data_req) begin
                reqs++;
                chk({name, "_daddr"}, data_addr, exp_daddr);
                chk({name, "_wstrb"}, {28'd0, data_wstrb}, {28'd0, exp_strb});
                chk({name, "_dwdata"}, data_wdata, exp_swd);
                chk({name, "_dwr"}, {31'd0, data_wr}, {31'd0, exp_wr});
            end
            if (!stallreq_o) done = 1;
            @(posedge clk); #1;
            k++;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk({name, "_finished"}, {31'd0, done}, 32'd1);
        chk({name, "_stalls"}, stalls, exp_stalls);
        chk({name, "_reqs"}, reqs, exp_reqs);
    endtask

    initial begin
        rst          = 1'b1;
        flush_i      = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        set_in(4'd5, 32'h1000, 32'h0, 32'h1234, 5'd3, 1'b1);
        #3;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_waddr", {27'd0, waddr_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        run_alu("alu", 4'd0, 32'h1234, 5'd3, 1'b1);
        run_alu("badop", 4'd7, 32'h0BAD, 5'd4, 1'b1);

        //          name    op    addr          sdata         wd     wa  ad dd rdata
        run_access("lb", 4'd1, 32'h1003, 32'h0, 32'h0, 5'd7, 0, 2, 32'h80FFFFFF,
                   32'h1003, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 3, 1);
        run_access("lbu", 4'd2, 32'h1003, 32'h0, 32'h0, 5'd8, 0, 2, 32'h80FFFFFF,
                   32'h1003, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h00000080, 3, 1);
        run_access("lh", 4'd3, 32'h1002, 32'h0, 32'h0, 5'd9, 1, 1, 32'h80017FFF,
                   32'h1002, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFF8001, 3, 2);
        run_access("lhu", 4'd4, 32'h1000, 32'h0, 32'h0, 5'd10, 0, 1, 32'h80017FFF,
                   32'h1000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h00007FFF, 2, 1);
        run_access("lw", 4'd5, 32'h1000, 32'h0, 32'h0, 5'd11, 0, 1, 32'hDEADBEEF,
                   32'h1000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 2, 1);
        run_access("sh", 4'd10, 32'h2002, 32'hABCD1234, 32'h55, 5'd12, 3, 1, 32'h0,
                   32'h2002, 4'b1100, 32'h12341234, 1'b1, 1'b0, 32'h55, 5, 4);
        run_access("sb", 4'd9, 32'h2001, 32'h000000A5, 32'h66, 5'd13, 0, 1, 32'h0,
                   32'h2001, 4'b0010, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h66, 2, 1);
        run_access("sw", 4'd11, 32'h2004, 32'hCAFEF00D, 32'h77, 5'd14, 0, 1, 32'h0,
                   32'h2004, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b0, 32'h77, 2, 1);
`ifndef MEM_UNALIGNED_EXC_EN
        run_access("lw_mask", 4'd5, 32'h1003, 32'h0, 32'h0, 5'd15, 0, 1, 32'h01020304,
                   32'h1000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h01020304, 2, 1);
        run_access("sh_mask", 4'd10, 32'h2003, 32'h0000BEEF, 32'h0, 5'd16, 0, 1, 32'h0,
                   32'h2002, 4'b1100, 32'hBEEFBEEF, 1'b1, 1'b0, 32'h0, 2, 1);
`endif

        // Flush while waiting for data: DRAIN swallows data_ok, no writeback.
        mon_en = 1'b0;
        set_in(4'd5, 32'h1000, 32'h0, 32'h0, 5'd9, 1'b1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_issue_req", {31'd0, data_req}, 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        flush_i      = 1'b1;
        @(negedge clk);
        chk("fl_wait_stall", {31'd0, stallreq_o}, 32'd1);
        chk("fl_wait_req", {31'd0, data_req}, 32'd0);
        @(posedge clk); #1;
        flush_i      = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h11111111;
        @(negedge clk);
        chk("fl_drain_stall", {31'd0, stallreq_o}, 32'd0);
        chk("fl_drain_we", {31'd0, we_o}, 32'd0);
        chk("fl_drain_req", {31'd0, data_req}, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        mon_en = 1'b1;
        run_access("lw_after_fl", 4'd5, 32'h1004, 32'h0, 32'h0, 5'd17, 0, 1, 32'h22222222,
                   32'h1004, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h22222222, 2, 1);

        // Asynchronous reset in the middle of a pending request.
        mon_en = 1'b0;
        set_in(4'd11, 32'h2008, 32'h12345678, 32'h0, 5'd1, 1'b1);
        @(negedge clk);
        chk("ar_idle_req", {31'd0, data_req}, 32'd1);
        @(posedge clk); #1;
        chk("ar_req_held", {31'd0, data_req}, 32'd1);
        chk("ar_req_stall", {31'd0, stallreq_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_req_drop", {31'd0, data_req}, 32'd0);
        chk("ar_stall_drop", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        // Back in IDLE: a fresh access must issue in its first cycle.
        run_access("lw_after_rst", 4'd5, 32'h100C, 32'h0, 32'h0, 5'd18, 0, 1, 32'h33333333,
                   32'h100C, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h33333333, 2, 1);

`ifdef MEM_UNALIGNED_EXC_EN
        mon_en = 1'b0;
        set_in(4'd5, 32'h3001, 32'h0, 32'h0, 5'd19, 1'b1);
        @(negedge clk);
        chk("ale_flag", {31'd0, excp_ale_o}, 32'd1);
        chk("ale_badv", badvaddr_o, 32'h3001);
        chk("ale_req", {31'd0, data_req}, 32'd0);
        chk("ale_we", {31'd0, we_o}, 32'd0);
        chk("ale_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
`endif

        run_alu("alu_end", 4'd0, 32'hFEED0001, 5'd31, 1'b0);
        mon_en = 1'b0;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
